// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: dispatch allocation, CDB writeback, in-order retire and mispredict flush.
// Optional macro ROB_BYPASS_EN lets operand queries see the live CDB broadcast in the same cycle.
module reorder_buffer #(
  parameter int XLEN           = 32,
  parameter int REG_CNT_WIDTH  = 5,
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dec_ready,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
  input  logic                      dec_is_branch,
  input  logic                      dec_pred_taken,
  input  logic [XLEN-1:0]           dec_alt_pc,
  input  logic                      cdb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
  input  logic [XLEN-1:0]           cdb_val,
  input  logic                      cdb_taken,
  input  logic [ROB_SIZE_WIDTH-1:0] qry_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] qry_id2,
  output logic                      qry_ready1,
  output logic                      qry_ready2,
  output logic [XLEN-1:0]           qry_val1,
  output logic [XLEN-1:0]           qry_val2,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  output logic                      rob_ready,
  output logic [REG_CNT_WIDTH-1:0]  rob_rd,
  output logic [XLEN-1:0]           rob_val,
  output logic                      rob_flush,
  output logic [XLEN-1:0]           rob_flush_pc
);

  localparam int ENTRIES = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0]   FULL_CNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};
  localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ONE  = {{(ROB_SIZE_WIDTH-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0]       valid_r, done_r, br_r, pred_r, taken_r;
  logic [REG_CNT_WIDTH-1:0] rd_r  [ENTRIES];
  logic [XLEN-1:0]          val_r [ENTRIES];
  logic [XLEN-1:0]          alt_r [ENTRIES];

  logic [ROB_SIZE_WIDTH-1:0] head_r, tail_r;
  logic [ROB_SIZE_WIDTH:0]   count_r;

  logic full_s, commit_s, mispred_s, disp_s, wb_s;
  logic byp1_s, byp2_s;

  assign full_s      = (count_r == FULL_CNT);
  assign rob_full    = full_s;
  assign rob_head_id = head_r;
  assign rob_tail_id = tail_r;

  // Per-cycle control decisions; nothing is accepted while a flush pulse is visible
  always_comb begin
    commit_s  = valid_r[head_r] && done_r[head_r];
    mispred_s = commit_s && br_r[head_r] && (taken_r[head_r] != pred_r[head_r]);
    disp_s    = dec_ready && !full_s && !rob_flush;
    wb_s      = cdb_ready && !rob_flush && valid_r[cdb_rob_id];
  end

  // Operand lookups: stored completion, optionally overridden by the live broadcast
  always_comb begin
`ifdef ROB_BYPASS_EN
    byp1_s = cdb_ready && (cdb_rob_id == qry_id1) && valid_r[qry_id1];
    byp2_s = cdb_ready && (cdb_rob_id == qry_id2) && valid_r[qry_id2];
`else
    byp1_s = 1'b0;
    byp2_s = 1'b0;
`endif
    if (byp1_s) begin
      qry_ready1 = 1'b1;
      qry_val1   = cdb_val;
    end else if (valid_r[qry_id1] && done_r[qry_id1]) begin
      qry_ready1 = 1'b1;
      qry_val1   = val_r[qry_id1];
    end else begin
      qry_ready1 = 1'b0;
      qry_val1   = {XLEN{1'b0}};
    end
    if (byp2_s) begin
      qry_ready2 = 1'b1;
      qry_val2   = cdb_val;
    end else if (valid_r[qry_id2] && done_r[qry_id2]) begin
      qry_ready2 = 1'b1;
      qry_val2   = val_r[qry_id2];
    end else begin
      qry_ready2 = 1'b0;
      qry_val2   = {XLEN{1'b0}};
    end
  end

  // Entry storage, pointers, occupancy and the registered commit/flush outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r      <= {ENTRIES{1'b0}};
      done_r       <= {ENTRIES{1'b0}};
      br_r         <= {ENTRIES{1'b0}};
      pred_r       <= {ENTRIES{1'b0}};
      taken_r      <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        rd_r[i]  <= {REG_CNT_WIDTH{1'b0}};
        val_r[i] <= {XLEN{1'b0}};
        alt_r[i] <= {XLEN{1'b0}};
      end
      head_r       <= {ROB_SIZE_WIDTH{1'b0}};
      tail_r       <= {ROB_SIZE_WIDTH{1'b0}};
      count_r      <= {(ROB_SIZE_WIDTH+1){1'b0}};
      rob_ready    <= 1'b0;
      rob_rd       <= {REG_CNT_WIDTH{1'b0}};
      rob_val      <= {XLEN{1'b0}};
      rob_flush    <= 1'b0;
      rob_flush_pc <= {XLEN{1'b0}};
    end else begin
      rob_ready <= commit_s;
      rob_flush <= mispred_s;
      if (commit_s) begin
        rob_rd  <= rd_r[head_r];
        rob_val <= val_r[head_r];
      end
      if (mispred_s) begin
        rob_flush_pc <= alt_r[head_r];
      end
      if (wb_s) begin
        done_r[cdb_rob_id]  <= 1'b1;
        val_r[cdb_rob_id]   <= cdb_val;
        taken_r[cdb_rob_id] <= cdb_taken;
      end
      // A mispredicted commit discards every younger entry, including a same-cycle dispatch
      if (mispred_s) begin
        valid_r <= {ENTRIES{1'b0}};
        done_r  <= {ENTRIES{1'b0}};
        head_r  <= head_r + PTR_ONE;
        tail_r  <= head_r + PTR_ONE;
        count_r <= {(ROB_SIZE_WIDTH+1){1'b0}};
      end else begin
        if (disp_s) begin
          valid_r[tail_r] <= 1'b1;
          done_r[tail_r]  <= 1'b0;
          br_r[tail_r]    <= dec_is_branch;
          pred_r[tail_r]  <= dec_pred_taken;
          rd_r[tail_r]    <= dec_rd;
          alt_r[tail_r]   <= dec_alt_pc;
          tail_r          <= tail_r + PTR_ONE;
        end
        if (commit_s) begin
          valid_r[head_r] <= 1'b0;
          head_r          <= head_r + PTR_ONE;
        end
        case ({disp_s, commit_s})
          2'b10:   count_r <= count_r + {{ROB_SIZE_WIDTH{1'b0}}, 1'b1};
          2'b01:   count_r <= count_r - {{ROB_SIZE_WIDTH{1'b0}}, 1'b1};
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; hand-computed expectations per step.
module tb_reorder_buffer;

  logic        clk, rst_n;
  logic        dec_ready, dec_is_branch, dec_pred_taken;
  logic [4:0]  dec_rd;
  logic [31:0] dec_alt_pc;
  logic        cdb_ready, cdb_taken;
  logic [2:0]  cdb_rob_id;
  logic [31:0] cdb_val;
  logic [2:0]  qry_id1, qry_id2;
  logic        qry_ready1, qry_ready2;
  logic [31:0] qry_val1, qry_val2;
  logic        rob_full, rob_ready, rob_flush;
  logic [2:0]  rob_head_id, rob_tail_id;
  logic [4:0]  rob_rd;
  logic [31:0] rob_val, rob_flush_pc;

  int n_assert = 0;
  int n_fail   = 0;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_is_branch(dec_is_branch),
    .dec_pred_taken(dec_pred_taken), .dec_alt_pc(dec_alt_pc),
    .cdb_ready(cdb_ready), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
    .qry_id1(qry_id1), .qry_id2(qry_id2),
    .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
    .qry_val1(qry_val1), .qry_val2(qry_val2),
    .rob_full(rob_full), .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
    .rob_ready(rob_ready), .rob_rd(rob_rd), .rob_val(rob_val),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    dec_ready = 1'b0; dec_rd = 5'd0; dec_is_branch = 1'b0; dec_pred_taken = 1'b0;
    dec_alt_pc = 32'd0; cdb_ready = 1'b0; cdb_rob_id = 3'd0; cdb_val = 32'd0;
    cdb_taken = 1'b0; qry_id1 = 3'd0; qry_id2 = 3'd0;
    #3;
    chk("rst_ready", {31'd0, rob_ready}, 32'd0);
    chk("rst_flush", {31'd0, rob_flush}, 32'd0);
    chk("rst_rd", {27'd0, rob_rd}, 32'd0);
    chk("rst_val", rob_val, 32'd0);
    chk("rst_flush_pc", rob_flush_pc, 32'd0);
    chk("rst_head", {29'd0, rob_head_id}, 32'd0);
    chk("rst_tail", {29'd0, rob_tail_id}, 32'd0);
    chk("rst_full", {31'd0, rob_full}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic commit
    dec_ready = 1'b1; dec_rd = 5'd5;
    #1 chk("basic_tail_pre", {29'd0, rob_tail_id}, 32'd0);
    tick();
    dec_ready = 1'b0;
    chk("basic_tail_post", {29'd0, rob_tail_id}, 32'd1);
    cdb_ready = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h1234;
    tick();
    cdb_ready = 1'b0;
    chk("basic_no_early_commit", {31'd0, rob_ready}, 32'd0);
    tick();
    chk("basic_ready", {31'd0, rob_ready}, 32'd1);
    chk("basic_rd", {27'd0, rob_rd}, 32'd5);
    chk("basic_val", rob_val, 32'h1234);
    chk("basic_head", {29'd0, rob_head_id}, 32'd1);
    tick();
    chk("basic_ready_drop", {31'd0, rob_ready}, 32'd0);

    // Out-of-order completion, in-order commit
    do_reset();
    dec_ready = 1'b1; dec_rd = 5'd1; tick();
    dec_rd = 5'd2; tick();
    dec_ready = 1'b0;
    cdb_ready = 1'b1; cdb_rob_id = 3'd1; cdb_val = 32'hB; tick();
    cdb_rob_id = 3'd0; cdb_val = 32'hA;
    chk("ooo_hold", {31'd0, rob_ready}, 32'd0);
    tick();
    cdb_ready = 1'b0;
    chk("ooo_hold2", {31'd0, rob_ready}, 32'd0);
    tick();
    chk("ooo_c1_ready", {31'd0, rob_ready}, 32'd1);
    chk("ooo_c1_rd", {27'd0, rob_rd}, 32'd1);
    chk("ooo_c1_val", rob_val, 32'hA);
    tick();
    chk("ooo_c2_ready", {31'd0, rob_ready}, 32'd1);
    chk("ooo_c2_rd", {27'd0, rob_rd}, 32'd2);
    chk("ooo_c2_val", rob_val, 32'hB);
    chk("ooo_c2_head", {29'd0, rob_head_id}, 32'd2);
    tick();
    chk("ooo_idle", {31'd0, rob_ready}, 32'd0);

    // Full and wrap
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dec_rd = 5'(i + 1);
      tick();
    end
    chk("full_set", {31'd0, rob_full}, 32'd1);
    chk("full_tail_wrap", {29'd0, rob_tail_id}, 32'd0);
    dec_rd = 5'd9;
    tick();
    chk("full_9th_tail", {29'd0, rob_tail_id}, 32'd0);
    chk("full_9th_full", {31'd0, rob_full}, 32'd1);
    cdb_ready = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h55;
    tick();
    cdb_ready = 1'b0;
    chk("full_still", {31'd0, rob_full}, 32'd1);
    tick();
    chk("full_commit_ready", {31'd0, rob_ready}, 32'd1);
    chk("full_commit_rd", {27'd0, rob_rd}, 32'd1);
    chk("full_commit_val", rob_val, 32'h55);
    chk("full_clear", {31'd0, rob_full}, 32'd0);
    chk("full_tail_held", {29'd0, rob_tail_id}, 32'd0);
    chk("full_head", {29'd0, rob_head_id}, 32'd1);
    tick();
    dec_ready = 1'b0;
    chk("wrap_tail", {29'd0, rob_tail_id}, 32'd1);
    chk("wrap_full", {31'd0, rob_full}, 32'd1);
    chk("wrap_ready_drop", {31'd0, rob_ready}, 32'd0);

    // Mispredict flush
    do_reset();
    dec_ready = 1'b1; dec_rd = 5'd0; dec_is_branch = 1'b1; dec_pred_taken = 1'b0;
    dec_alt_pc = 32'h100; tick();
    dec_is_branch = 1'b0; dec_alt_pc = 32'd0; dec_rd = 5'd3; tick();
    dec_rd = 5'd4; tick();
    dec_ready = 1'b0;
    cdb_ready = 1'b1; cdb_rob_id = 3'd1; cdb_val = 32'h77; cdb_taken = 1'b0; tick();
    cdb_rob_id = 3'd0; cdb_val = 32'd0; cdb_taken = 1'b1; tick();
    cdb_ready = 1'b0; cdb_taken = 1'b0;
    qry_id1 = 3'd1;
    #1;
    chk("mp_qry_pre_rdy", {31'd0, qry_ready1}, 32'd1);
    chk("mp_qry_pre_val", qry_val1, 32'h77);
    tick();
    chk("mp_ready", {31'd0, rob_ready}, 32'd1);
    chk("mp_rd", {27'd0, rob_rd}, 32'd0);
    chk("mp_flush", {31'd0, rob_flush}, 32'd1);
    chk("mp_flush_pc", rob_flush_pc, 32'h100);
    chk("mp_head", {29'd0, rob_head_id}, 32'd1);
    chk("mp_tail", {29'd0, rob_tail_id}, 32'd1);
    chk("mp_qry_killed", {31'd0, qry_ready1}, 32'd0);
    dec_ready = 1'b1; dec_rd = 5'd7;
    cdb_ready = 1'b1; cdb_rob_id = 3'd1; cdb_val = 32'h5;
    tick();
    dec_ready = 1'b0; cdb_ready = 1'b0;
    chk("mp_flush_drop", {31'd0, rob_flush}, 32'd0);
    chk("mp_ready_drop", {31'd0, rob_ready}, 32'd0);
    chk("mp_disp_ignored", {29'd0, rob_tail_id}, 32'd1);
    chk("mp_head_eq_tail", {29'd0, rob_head_id}, 32'd1);
    chk("mp_not_full", {31'd0, rob_full}, 32'd0);
    chk("mp_wb_ignored", {31'd0, qry_ready1}, 32'd0);

    // Query and bypass
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dec_rd = 5'(i + 1);
      tick();
    end
    dec_ready = 1'b0;
    cdb_ready = 1'b1; cdb_rob_id = 3'd3; cdb_val = 32'd7; tick();
    cdb_ready = 1'b0;
    qry_id1 = 3'd3; qry_id2 = 3'd2;
    #1;
    chk("qry1_ready", {31'd0, qry_ready1}, 32'd1);
    chk("qry1_val", qry_val1, 32'd7);
    chk("qry2_pending_rdy", {31'd0, qry_ready2}, 32'd0);
    chk("qry2_pending_val", qry_val2, 32'd0);
    cdb_ready = 1'b1; cdb_rob_id = 3'd4; cdb_val = 32'h99; qry_id2 = 3'd4;
    #1;
`ifdef ROB_BYPASS_EN
    chk("qry_byp_rdy", {31'd0, qry_ready2}, 32'd1);
    chk("qry_byp_val", qry_val2, 32'h99);
`else
    chk("qry_nobyp_rdy", {31'd0, qry_ready2}, 32'd0);
    chk("qry_nobyp_val", qry_val2, 32'd0);
`endif
    tick();
    cdb_ready = 1'b0;
    chk("qry_late_rdy", {31'd0, qry_ready2}, 32'd1);
    chk("qry_late_val", qry_val2, 32'h99);
    chk("qry_no_commit", {31'd0, rob_ready}, 32'd0);

    // Async reset with entries pending and a commit pulse visible
    cdb_ready = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h11; tick();
    cdb_ready = 1'b0;
    tick();
    chk("ar_pre_ready", {31'd0, rob_ready}, 32'd1);
    chk("ar_pre_val", rob_val, 32'h11);
    chk("ar_pre_tail", {29'd0, rob_tail_id}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", {31'd0, rob_ready}, 32'd0);
    chk("ar_rd", {27'd0, rob_rd}, 32'd0);
    chk("ar_val", rob_val, 32'd0);
    chk("ar_head", {29'd0, rob_head_id}, 32'd0);
    chk("ar_tail", {29'd0, rob_tail_id}, 32'd0);
    chk("ar_qry", {31'd0, qry_ready1}, 32'd0);
    chk("ar_flush", {31'd0, rob_flush}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer between the decoder/dispatch stage and the register file.
- Allocates one entry per dispatched instruction and captures results from the common data bus (CDB).
- Retires the head entry in order, producing the rob_ready/rob_rd/rob_val/rob_head_id/rob_tail_id signals the register file consumes.
- Detects branch mispredictions at commit and raises flush.

Parameters:
- XLEN, 32, data width.
- REG_CNT_WIDTH, 5, architectural register index width.
- ROB_SIZE_WIDTH, 3, log2 of entry count; entries = 2**ROB_SIZE_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_ready  in  1  dispatch request this cycle.
- dec_rd  in  REG_CNT_WIDTH  destination register; 0 = none (branch/store/x0).
- dec_is_branch  in  1  entry is a conditional branch.
- dec_pred_taken  in  1  predicted direction.
- dec_alt_pc  in  XLEN  redirect target used if the prediction is wrong.
- cdb_ready  in  1  result broadcast valid.
- cdb_rob_id  in  ROB_SIZE_WIDTH  entry being completed.
- cdb_val  in  XLEN  result value.
- cdb_taken  in  1  actual branch outcome (branches only).
- qry_id1, qry_id2  in  ROB_SIZE_WIDTH  operand dependency lookups.
- qry_ready1, qry_ready2  out  1  queried entry is valid and completed.
- qry_val1, qry_val2  out  XLEN  queried entry value.
- rob_full  out  1  no free entry.
- rob_head_id  out  ROB_SIZE_WIDTH  head pointer (next entry to commit).
- rob_tail_id  out  ROB_SIZE_WIDTH  id assigned to a dispatch in this cycle.
- rob_ready  out  1  registered commit pulse.
- rob_rd  out  REG_CNT_WIDTH  committed destination.
- rob_val  out  XLEN  committed value.
- rob_flush  out  1  registered misprediction pulse.
- rob_flush_pc  out  XLEN  redirect PC, valid while rob_flush is high.

Behaviour:
- Storage per entry: valid, done, rd, val, is_branch, pred_taken, taken, alt_pc.
- Pointers and count:
  - head and tail are ROB_SIZE_WIDTH-bit and wrap modulo the entry count.
  - count is ROB_SIZE_WIDTH+1 bits.
  - rob_full = (count == 2**ROB_SIZE_WIDTH), combinational from count.
- Reset (async, rst_n=0):
  - head, tail, count = 0; all valid/done = 0.
  - rob_ready, rob_flush, rob_rd, rob_val, rob_flush_pc = 0.
  - rob_head_id = rob_tail_id = 0.
- Dispatch:
  - Occurs when dec_ready && !rob_full && !rob_flush.
  - Writes entry[tail] (valid=1, done=0) and advances tail by 1.
  - When rob_full is high, dispatch is ignored even if a commit happens in the same cycle.
  - The decoder holds dec_ready until accepted.
- Writeback:
  - cdb_ready sets entry[cdb_rob_id].done=1 and stores val and taken.
  - Writeback to an invalid entry is ignored.
- Commit (at most one per cycle):
  - Condition: entry[head].valid && entry[head].done.
  - Next edge:
    - rob_ready=1, rob_rd=entry.rd, rob_val=entry.val.
    - Entry invalidated; head advances.
  - Consequently, in the cycle rob_ready is high, rob_head_id equals the committed id + 1 (mod size). The register file depends on this relation.
  - rob_ready is deasserted the following cycle unless another commit occurs.
  - Commit with rd=0 still pulses rob_ready, with rob_rd=0.
- Misprediction:
  - A committed branch with taken != pred_taken additionally pulses rob_flush=1 with rob_flush_pc=alt_pc, in the same cycle as its rob_ready.
  - On that edge all entries are invalidated, tail is set to the new head, and count = 0.
  - Dispatch and writeback presented during the rob_flush cycle are ignored.
- Simultaneous dispatch and commit: count unchanged; both pointers advance.
- Query:
  - Combinational: qry_readyN = entry[qry_idN].valid && done; qry_valN = entry[qry_idN].val.
  - qry_valN is 0 when qry_readyN is low.
- Pointer wrap: id 2**ROB_SIZE_WIDTH-1 is followed by 0, and every comparison uses the wrapped value.

Optional Feature:
- ROB_BYPASS_EN:
  - Defined: the queries also match the live CDB. If cdb_ready && cdb_rob_id==qry_idN && entry valid, then qry_readyN=1 and qry_valN=cdb_val in the same cycle.
  - Undefined: the query reflects stored state only, so the result is visible one cycle after writeback.

Test Plan:
- Basic commit: reset; dispatch rd=5 (id 0); CDB id 0 val 0x1234 → next edge rob_ready=1, rob_rd=5, rob_val=0x1234, rob_head_id=1.
- Out-of-order completion: dispatch ids 0 (rd=1) and 1 (rd=2); CDB id 1 first, then id 0 → commit order rd=1 then rd=2 on consecutive cycles.
- Full and wrap: 8 dispatches → rob_full=1 and a 9th dispatch is ignored (tail stays 0). Complete and commit 1 → rob_full=0. Next dispatch gets id 0, and tail wraps 7→0.
- Mispredict: branch pred_taken=0, alt_pc=0x100, CDB taken=1, younger entries pending → rob_flush=1 with flush_pc=0x100 in the same cycle as rob_ready (rd=0). Then count=0 and head=tail.
- Query: entry 3 done with val 7 → qry_id1=3 gives ready=1, val=7. With ROB_BYPASS_EN, a CDB to id 4 gives ready=1 in the same cycle; without it, ready=1 one cycle later.
- Async reset mid-operation: assert rst_n=0 with 4 entries pending and rob_ready high → all outputs 0 immediately, without waiting for clk.
